rf_scoreboard: RTL and testbench

Register-file scoreboard for the 5-stage ARM pipeline. Tracks, per architectural register R0–R14, how many issued instructions still have a pending write-back, and raises the Hazard stall to the decode stage whenever the decoding instruction reads a register with an outstanding write. It sits beside the decode stage, observes the decoded instruction and the write-back port, and schedules use of the register file's read ports against in-flight writes.

---
 rtl/rf_scoreboard.sv | 106 ++++++++++
 tb/tb_rf_scoreboard.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write tracker for the 5-stage ARM
// pipeline. Each of R0-R14 has a saturating 2-bit count of issued
// instructions whose write-back has not yet happened. Decode is stalled
// (hazard) when it reads a register with an outstanding write that is not
// retiring this very cycle. R15 (PC) is never tracked.
//
// Optional feature: define RF_SCOREBOARD_STATS_EN to add a stall-cycle
// counter (stall_cnt) with a synchronous clear input (stats_clr).
module rf_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        id_valid,
  input  logic        id_wb_en,
  input  logic [3:0]  id_dest,
  input  logic [3:0]  id_src1,
  input  logic [3:0]  id_src2,
  input  logic        id_two_src,
  input  logic        wb_wb_en,
  input  logic [3:0]  wb_dest,
  output logic        hazard,
  output logic        busy,
  output logic [14:0] pending_mask,
  output logic        overflow,
  output logic        underflow
`ifdef RF_SCOREBOARD_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [15:0] stall_cnt
`endif
);

  logic [1:0]  cnt [15];
  logic        retire;
  logic        issue;
  logic [14:0] inc_vec;
  logic [14:0] dec_vec;
  // Bit 15 stays zero so a PC operand can never report an outstanding write.
  logic [15:0] eff_nz;

  // Decode-side view: which registers are still pending once this cycle's
  // retiring write is accounted for, and whether decode must stall or issue.
  always_comb begin
    retire  = wb_wb_en & ~freeze & (wb_dest != 4'd15);
    dec_vec = '0;
    eff_nz  = '0;
    pending_mask = '0;
    for (int i = 0; i < 15; i++) begin
      dec_vec[i]      = retire & (wb_dest == 4'(i));
      pending_mask[i] = (cnt[i] != 2'd0);
      eff_nz[i]       = (cnt[i] > 2'd1) | ((cnt[i] == 2'd1) & ~dec_vec[i]);
    end
    hazard = id_valid & ~flush &
             (eff_nz[id_src1] | (id_two_src & eff_nz[id_src2]));
    issue  = id_valid & id_wb_en & ~hazard & ~flush & ~freeze &
             (id_dest != 4'd15);
    inc_vec = '0;
    for (int i = 0; i < 15; i++) begin
      inc_vec[i] = issue & (id_dest == 4'(i));
    end
    busy = |pending_mask;
  end

  // Counter update: issue and retire on the same register cancel; otherwise
  // saturate at 3 / 0 and record the misuse in the sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 15; i++) begin
        cnt[i] <= 2'd0;
      end
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      for (int i = 0; i < 15; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          if (cnt[i] == 2'd3) begin
            overflow <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] + 2'd1;
          end
        end else if (dec_vec[i] && !inc_vec[i]) begin
          if (cnt[i] == 2'd0) begin
            underflow <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] - 2'd1;
          end
        end
      end
    end
  end

`ifdef RF_SCOREBOARD_STATS_EN
  // Stall statistics: counts non-frozen hazard cycles, saturating; clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 16'd0;
    end else if (stats_clr) begin
      stall_cnt <= 16'd0;
    end else if (hazard && !freeze && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: directed test of rf_scoreboard against a behavioural
// model holding plain integer pending counts per register. Define
// RF_SCOREBOARD_STATS_EN to also exercise the stall counter.
module tb_rf_scoreboard;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        flush;
  logic        id_valid;
  logic        id_wb_en;
  logic [3:0]  id_dest;
  logic [3:0]  id_src1;
  logic [3:0]  id_src2;
  logic        id_two_src;
  logic        wb_wb_en;
  logic [3:0]  wb_dest;
  logic        hazard;
  logic        busy;
  logic [14:0] pending_mask;
  logic        overflow;
  logic        underflow;
`ifdef RF_SCOREBOARD_STATS_EN
  logic        stats_clr;
  logic [15:0] stall_cnt;
  int          m_stall;
`endif

  int m_cnt [15];
  bit m_ovf;
  bit m_unf;
  int pass_cnt;
  int total_cnt;

  rf_scoreboard dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .wb_wb_en(wb_wb_en), .wb_dest(wb_dest),
    .hazard(hazard), .busy(busy), .pending_mask(pending_mask),
    .overflow(overflow), .underflow(underflow)
`ifdef RF_SCOREBOARD_STATS_EN
    , .stats_clr(stats_clr), .stall_cnt(stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pending writes to r that remain after this cycle's retire (never negative).
  function automatic int m_eff(input logic [3:0] r);
    int e;
    if (r == 4'd15) return 0;
    e = m_cnt[r];
    if (wb_wb_en && !freeze && wb_dest == r && e > 0) e = e - 1;
    return e;
  endfunction

  function automatic bit m_hazard();
    return id_valid && !flush &&
           (m_eff(id_src1) != 0 || (id_two_src && m_eff(id_src2) != 0));
  endfunction

  function automatic logic [14:0] m_mask();
    logic [14:0] m;
    m = '0;
    for (int i = 0; i < 15; i++) m[i] = (m_cnt[i] != 0);
    return m;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Model update at each rising edge from the inputs held during the cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 15; i++) m_cnt[i] = 0;
      m_ovf = 0;
      m_unf = 0;
`ifdef RF_SCOREBOARD_STATS_EN
      m_stall = 0;
`endif
    end else begin
      bit h, ret, iss;
      h   = m_hazard();
      ret = wb_wb_en && !freeze && wb_dest != 4'd15;
      iss = id_valid && id_wb_en && !h && !flush && !freeze && id_dest != 4'd15;
`ifdef RF_SCOREBOARD_STATS_EN
      if (stats_clr) m_stall = 0;
      else if (h && !freeze && m_stall < 65535) m_stall++;
`endif
      if (!(iss && ret && id_dest == wb_dest)) begin
        if (iss) begin
          if (m_cnt[id_dest] == 3) m_ovf = 1;
          else m_cnt[id_dest]++;
        end
        if (ret) begin
          if (m_cnt[wb_dest] == 0) m_unf = 1;
          else m_cnt[wb_dest]--;
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      check_output("rst_hazard", {31'd0, hazard}, 32'd0);
      check_output("rst_busy", {31'd0, busy}, 32'd0);
      check_output("rst_mask", {17'd0, pending_mask}, 32'd0);
      check_output("rst_flags", {30'd0, overflow, underflow}, 32'd0);
    end else begin
      check_output("cyc_hazard", {31'd0, hazard}, {31'd0, m_hazard()});
      check_output("cyc_mask", {17'd0, pending_mask}, {17'd0, m_mask()});
      check_output("cyc_busy", {31'd0, busy}, {31'd0, (m_mask() != 0)});
      check_output("cyc_overflow", {31'd0, overflow}, {31'd0, m_ovf});
      check_output("cyc_underflow", {31'd0, underflow}, {31'd0, m_unf});
`ifdef RF_SCOREBOARD_STATS_EN
      check_output("cyc_stall_cnt", {16'd0, stall_cnt}, m_stall);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic we, input logic [3:0] d,
                        input logic [3:0] s1, input logic [3:0] s2, input logic two);
    id_valid = v; id_wb_en = we; id_dest = d;
    id_src1 = s1; id_src2 = s2; id_two_src = two;
  endtask

  task automatic set_wb(input logic en, input logic [3:0] d);
    wb_wb_en = en; wb_dest = d;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst = 1'b0; freeze = 1'b0; flush = 1'b0;
`ifdef RF_SCOREBOARD_STATS_EN
    stats_clr = 1'b0;
`endif
    set_id(0, 0, 0, 0, 0, 0);
    set_wb(0, 0);
    step(2);
    check_output("reset_busy", {31'd0, busy}, 32'd0);
    check_output("reset_flags", {30'd0, overflow, underflow}, 32'd0);
    rst = 1'b1;
    step(1);

    // Idle scoreboard: reading R3 never stalls.
    set_id(1, 0, 0, 3, 0, 0); #1;
    check_output("idle_hazard", {31'd0, hazard}, 32'd0);
    check_output("idle_mask", {17'd0, pending_mask}, 32'd0);

    // Producer to R2, dependent consumer stalls until R2 is in write-back.
    set_id(1, 1, 2, 0, 1, 1);
    step(1);
    set_id(1, 1, 3, 2, 0, 0); #1;
    check_output("dep_hazard", {31'd0, hazard}, 32'd1);
    check_output("dep_mask", {17'd0, pending_mask}, 32'h0004);
    check_output("model_cnt2", m_cnt[2], 32'd1);
    step(2);
    check_output("dep_hold", {31'd0, hazard}, 32'd1);
    set_wb(1, 2); #1;
    check_output("dep_release", {31'd0, hazard}, 32'd0);
    step(1);
    set_id(0, 0, 0, 0, 0, 0); set_wb(0, 0); #1;
    check_output("dep_after_mask", {17'd0, pending_mask}, 32'h0008);
    set_wb(1, 3); step(1); set_wb(0, 0);

    // Same-cycle issue and retire on R5 cancel out.
    set_id(1, 1, 5, 0, 0, 0); step(1);
    set_wb(1, 5); step(1);
    set_id(0, 0, 0, 0, 0, 0); set_wb(0, 0); #1;
    check_output("cancel_mask", {17'd0, pending_mask}, 32'h0020);
    check_output("cancel_flags", {30'd0, overflow, underflow}, 32'd0);
    set_wb(1, 5); step(1); set_wb(0, 0);

    // Four issues to R7 saturate and overflow; retire of idle R9 underflows.
    set_id(1, 1, 7, 0, 0, 0); step(3);
    check_output("sat_no_ovf_yet", {31'd0, overflow}, 32'd0);
    step(1);
    check_output("sat_ovf", {31'd0, overflow}, 32'd1);
    check_output("sat_mask", {17'd0, pending_mask}, 32'h0080);
    check_output("model_cnt7", m_cnt[7], 32'd3);
    set_id(0, 0, 0, 0, 0, 0); set_wb(1, 9); step(1); set_wb(0, 0);
    check_output("unf_flag", {31'd0, underflow}, 32'd1);
    set_wb(1, 7); step(3); set_wb(0, 0);
    check_output("sat_drained", {31'd0, busy}, 32'd0);

    // Freeze blocks both issue and retire but hazard remains live.
    set_id(1, 1, 2, 0, 0, 0); step(1);
    freeze = 1'b1; set_id(1, 1, 4, 6, 0, 0); set_wb(1, 2);
    step(2);
    check_output("freeze_mask", {17'd0, pending_mask}, 32'h0004);
    set_id(1, 0, 4, 2, 0, 0); #1;
    check_output("freeze_hazard", {31'd0, hazard}, 32'd1);
    freeze = 1'b0; #1;
    check_output("unfreeze_hazard", {31'd0, hazard}, 32'd0);
    step(1);
    set_id(0, 0, 0, 0, 0, 0); set_wb(0, 0);

    // Flush suppresses both hazard and issue.
    set_id(1, 1, 1, 0, 0, 0); step(1);
    flush = 1'b1; set_id(1, 1, 3, 1, 0, 0); #1;
    check_output("flush_hazard", {31'd0, hazard}, 32'd0);
    step(1);
    flush = 1'b0; set_id(0, 0, 0, 0, 0, 0); #1;
    check_output("flush_mask", {17'd0, pending_mask}, 32'h0002);

    // R15 is never tracked nor hazarded.
    set_id(1, 1, 15, 15, 15, 1); #1;
    check_output("pc_hazard", {31'd0, hazard}, 32'd0);
    step(1);
    check_output("pc_mask", {17'd0, pending_mask}, 32'h0002);
    set_id(0, 0, 0, 0, 0, 0); set_wb(1, 15); step(1); set_wb(0, 0);

`ifdef RF_SCOREBOARD_STATS_EN
    // Ten hazard cycles, three frozen, after a clear.
    set_id(1, 0, 0, 1, 0, 0); stats_clr = 1'b1; step(1); stats_clr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      freeze = (k < 3);
      step(1);
    end
    freeze = 1'b0; set_id(0, 0, 0, 0, 0, 0); #1;
    check_output("stall_seven", {16'd0, stall_cnt}, 32'd7);
    stats_clr = 1'b1; step(1); stats_clr = 1'b0; #1;
    check_output("stall_clr", {16'd0, stall_cnt}, 32'd0);
`endif

    // Asynchronous reset mid-cycle discards tracking immediately.
    check_output("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0; #1;
    check_output("async_busy", {31'd0, busy}, 32'd0);
    check_output("async_flags", {30'd0, overflow, underflow}, 32'd0);
    step(1);
    rst = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
